// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad responder: FSM state encoding, button
// bit positions on the buttons bus, and shift counter sizing.
package joypad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_e;

   // Bit positions on the buttons bus (and in the shift register)
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam int NUM_BTNS = 8;
   localparam int CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'd8;

endpackage

// File: rtl/joypad_responder_if.sv
// Console-side serial bus plus local button inputs and status outputs.
//   ctlr_latch, ctlr_pulse : console strobe / shift clock (async to clock)
//   buttons                : raw active-high switches
//   ctlr_data              : serial data, active-low
//   shift_count            : shifts since last load, saturating at 8
//   read_done              : one-cycle pulse on the eighth shift
// master = console/bench side, slave = responder side.
interface joypad_responder_if;
   import joypad_pkg::*;

   logic                ctlr_latch;
   logic                ctlr_pulse;
   logic [NUM_BTNS-1:0] buttons;
   logic                ctlr_data;
   logic [CNT_W-1:0]    shift_count;
   logic                read_done;

   modport master (
      output ctlr_latch, ctlr_pulse, buttons,
      input  ctlr_data, shift_count, read_done
   );

   modport slave (
      input  ctlr_latch, ctlr_pulse, buttons,
      output ctlr_data, shift_count, read_done
   );
endinterface

// File: rtl/input_sync.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
//   clock, reset_n : system clock, async active-low reset (flops clear to 0)
//   d_i            : asynchronous inputs
//   q_o            : inputs after STAGES flops in the clock domain
module input_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/joypad_responder.sv
// Game controller responder: synchronizes the console latch/pulse lines and
// the button switches, debounces the buttons, and serializes them onto
// ctlr_data (active-low, button A first) with an IDLE/LOAD/SHIFT FSM.
//   clock, reset_n : system clock, async active-low reset
//   jp (slave)     : ctlr_latch, ctlr_pulse, buttons in;
//                    ctlr_data, shift_count, read_done out
module joypad_responder
   import joypad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_PERIOD   = 1000
) (
   input  logic               clock,
   input  logic               reset_n,
   joypad_responder_if.slave  jp
);

   localparam int DB_W = $clog2(DB_PERIOD);

   logic [1:0]          ctl_s;
   logic [NUM_BTNS-1:0] btn_s;
   logic                latch_s, pulse_s;

   input_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_ctl_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     ({jp.ctlr_pulse, jp.ctlr_latch}),
      .q_o     (ctl_s)
   );

   input_sync #(.WIDTH(NUM_BTNS), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (jp.buttons),
      .q_o     (btn_s)
   );

   assign latch_s = ctl_s[0];
   assign pulse_s = ctl_s[1];

   state_e              state_q, state_d;
   logic [NUM_BTNS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic                latch_dly_q, pulse_dly_q;
   logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
   logic [NUM_BTNS-1:0] samp_q, samp_d, db_q, db_d;
   logic                db_tick, latch_fall, pulse_rise;
   logic                load_en, shift_en;
   logic [NUM_BTNS-1:0] agree;

   assign latch_fall = latch_dly_q & ~latch_s;
   assign pulse_rise = pulse_s & ~pulse_dly_q;

   // Debounce: sample at each wrap; a bit moves only when this sample and
   // the previous one agree.
   assign db_tick  = (db_cnt_q == DB_W'(DB_PERIOD - 1));
   assign db_cnt_d = db_tick ? '0 : db_cnt_q + DB_W'(1);
   assign samp_d   = db_tick ? btn_s : samp_q;
   assign agree    = ~(btn_s ^ samp_q);
   assign db_d     = db_tick ? ((agree & btn_s) | (~agree & db_q)) : db_q;

   // Load decision is taken from the synchronized latch directly (not from
   // the registered state) so data appears SYNC_STAGES+1 clocks after the pin.
   always_comb begin
      state_d  = state_q;
      load_en  = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (latch_s) begin
               state_d = LOAD;
               load_en = 1'b1;
            end
         end
         LOAD: begin
            load_en = 1'b1;
            if (latch_fall) state_d = SHIFT;
         end
         SHIFT: begin
            if (latch_s) begin
               state_d = LOAD;
               load_en = 1'b1;
            end else if (pulse_rise) begin
               shift_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      rd_d  = 1'b0;
      if (load_en) begin
         sr_d  = ~db_q;
         cnt_d = '0;
      end else if (shift_en) begin
         sr_d = {1'b1, sr_q[NUM_BTNS-1:1]};
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         rd_d = (cnt_q == CNT_MAX - CNT_W'(1));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sr_q        <= '1;
         cnt_q       <= '0;
         rd_q        <= 1'b0;
         latch_dly_q <= 1'b0;
         pulse_dly_q <= 1'b0;
         db_cnt_q    <= '0;
         samp_q      <= '0;
         db_q        <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         latch_dly_q <= latch_s;
         pulse_dly_q <= pulse_s;
         db_cnt_q    <= db_cnt_d;
         samp_q      <= samp_d;
         db_q        <= db_d;
      end
   end

   assign jp.ctlr_data   = sr_q[BTN_A];
   assign jp.shift_count = cnt_q;
   assign jp.read_done   = rd_q;

endmodule

// File: tb/tb_joypad_responder.sv
// Scoreboard bench for joypad_responder: expected ctlr_data/shift_count are
// queued when latch/pulse stimulus is driven and popped at the output time.
module tb_joypad_responder;
   import joypad_pkg::*;

   localparam int SYNC = 2;
   localparam int DBP  = 8;
   localparam int LAT  = SYNC + 1;

   typedef struct {
      logic       data;
      logic [3:0] cnt;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   joypad_responder_if jp();

   joypad_responder #(.SYNC_STAGES(SYNC), .DB_PERIOD(DBP)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .jp      (jp)
   );

   always #5 clock = ~clock;

   int   n_vec = 0;
   int   n_err = 0;
   int   rd_total = 0;
   exp_t sb[$];
   logic [7:0] exp_sr;
   logic [7:0] db_exp;
   int   exp_cnt;
   int   rd0;

   always @(negedge clock) if (jp.read_done === 1'b1) rd_total <= rd_total + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(jp.ctlr_data), 32'(e.data));
      chk({tag, "_cnt"}, 32'(jp.shift_count), 32'(e.cnt));
   endtask

   task automatic push_exp();
      exp_t e;
      e.data = exp_sr[0];
      e.cnt  = 4'(exp_cnt);
      sb.push_back(e);
   endtask

   task automatic do_latch(input string tag);
      logic prev;
      prev = exp_sr[0];
      jp.ctlr_latch = 1'b1;
      exp_sr  = ~db_exp;
      exp_cnt = 0;
      push_exp();
      tick(LAT - 1);
      chk({tag, "_early"}, 32'(jp.ctlr_data), 32'(prev));
      tick(1);
      sb_check(tag);
      jp.ctlr_latch = 1'b0;
      tick(4);
   endtask

   task automatic do_pulse(input string tag);
      logic prev;
      prev = exp_sr[0];
      jp.ctlr_pulse = 1'b1;
      exp_sr = {1'b1, exp_sr[7:1]};
      if (exp_cnt < 8) exp_cnt++;
      push_exp();
      tick(LAT - 1);
      chk({tag, "_early"}, 32'(jp.ctlr_data), 32'(prev));
      tick(1);
      sb_check(tag);
      jp.ctlr_pulse = 1'b0;
      tick(3);
   endtask

   task automatic hold_buttons(input logic [7:0] b);
      jp.buttons = b;
      tick(5 * DBP);
      db_exp = b;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset_n       = 1'b0;
      jp.ctlr_latch = 1'b0;
      jp.ctlr_pulse = 1'b0;
      jp.buttons    = 8'h00;
      exp_sr  = 8'hFF;
      exp_cnt = 0;
      db_exp  = 8'h00;
      tick(3);
      chk("rst_data",  32'(jp.ctlr_data), 32'd1);
      chk("rst_cnt",   32'(jp.shift_count), 32'd0);
      chk("rst_rd",    32'(jp.read_done), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      reset_n = 1'b1;
      tick(2);

      // Buttons Start+A, eight pulses
      hold_buttons(8'h09);
      rd0 = rd_total;
      do_latch("s1_latch");
      for (int i = 0; i < 8; i++) do_pulse($sformatf("s1_p%0d", i + 1));
      chk("s1_rd_once", 32'(rd_total - rd0), 32'd1);

      // Ten pulses: counter saturates, trailing bits read 1
      rd0 = rd_total;
      do_latch("s2_latch");
      for (int i = 0; i < 10; i++) do_pulse($sformatf("s2_p%0d", i + 1));
      chk("s2_rd_once", 32'(rd_total - rd0), 32'd1);

      // Glitch shorter than a debounce period is rejected
      hold_buttons(8'h00);
      jp.buttons = 8'h01;
      tick(3);
      jp.buttons = 8'h00;
      tick(3 * DBP);
      do_latch("s3_glitch");
      hold_buttons(8'h01);
      do_latch("s3_stable");

      // Debounce moves during SHIFT but shift register is untouched
      do_pulse("s4_p0");
      hold_buttons(8'hFF);
      chk("s4_hold_data", 32'(jp.ctlr_data), 32'(exp_sr[0]));
      chk("s4_hold_cnt",  32'(jp.shift_count), 32'(exp_cnt));
      do_latch("s4_latch");
      for (int i = 0; i < 3; i++) do_pulse($sformatf("s4_p%0d", i + 1));
      do_latch("s4_relatch");

      // Latch and pulse rising together: load wins
      do_pulse("s5_p0");
      jp.ctlr_latch = 1'b1;
      jp.ctlr_pulse = 1'b1;
      exp_sr  = ~db_exp;
      exp_cnt = 0;
      push_exp();
      tick(LAT);
      sb_check("s5_both");
      chk("s5_state", 32'(dut.state_q), 32'(LOAD));
      jp.ctlr_latch = 1'b0;
      jp.ctlr_pulse = 1'b0;
      tick(4);
      chk("s5_shift_state", 32'(dut.state_q), 32'(SHIFT));
      do_pulse("s5_p1");

      // Asynchronous reset mid-read
      do_latch("s6_latch");
      for (int i = 0; i < 4; i++) do_pulse($sformatf("s6_p%0d", i + 1));
      #2 reset_n = 1'b0;
      #1;
      chk("s6_rst_data",  32'(jp.ctlr_data), 32'd1);
      chk("s6_rst_cnt",   32'(jp.shift_count), 32'd0);
      chk("s6_rst_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clock);
      reset_n = 1'b1;
      exp_sr  = 8'hFF;
      exp_cnt = 0;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         jp.ctlr_pulse = 1'b1;
         tick(LAT);
         chk($sformatf("s6_nolatch_data%0d", i), 32'(jp.ctlr_data), 32'd1);
         chk($sformatf("s6_nolatch_cnt%0d", i),  32'(jp.shift_count), 32'd0);
         jp.ctlr_pulse = 1'b0;
         tick(3);
      end
      chk("s6_idle", 32'(dut.state_q), 32'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/joypad_responder.md
JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in each input synchronizer, minimum 2.
REQ-002 SHALL have parameter DB_PERIOD, default 1000: clock cycles between debounce samples, minimum 2.
REQ-003 SHALL have port clock, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ctlr_latch, input, 1: strobe from console side; asynchronous to clock.
REQ-006 SHALL have port ctlr_pulse, input, 1: shift clock from console side; asynchronous to clock.
REQ-007 SHALL have port buttons, input, 8: raw active-high switches, order bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-008 SHALL have port ctlr_data, output, 1: serial button data, active-low (0 = pressed, 1 = released or no data).
REQ-009 SHALL have port shift_count, output, 4: number of shifts since the last load, saturating at 8.
REQ-010 SHALL have port read_done, output, 1: one-cycle pulse when the eighth shift completes.

Function
REQ-011 ctlr_latch, ctlr_pulse and each buttons bit SHALL pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-012 Edge detection SHALL compare each synchronized signal with a one-cycle-delayed copy of itself.
REQ-013 Debounce: a free-running counter SHALL wrap 0..DB_PERIOD-1 and produce a tick at wrap.
REQ-014 Debounce: a button's debounced bit SHALL change only when two consecutive tick samples agree and differ from the current debounced value.
REQ-015 FSM states SHALL be IDLE, LOAD and SHIFT.
REQ-016 IDLE -> LOAD on synchronized latch high; SHIFT -> LOAD on synchronized latch high.
REQ-017 LOAD -> SHIFT on the synchronized latch falling edge.
REQ-018 SHIFT SHALL remain in SHIFT while latch is low; there is no SHIFT -> IDLE transition except by reset.
REQ-019 In LOAD, the 8-bit shift register SHALL reload ~debounced_buttons every cycle, and shift_count SHALL be held at 0.
REQ-020 In LOAD, pulse edges SHALL be ignored; reload dominates.
REQ-021 In SHIFT, a synchronized pulse rising edge SHALL shift the register right with 1 entering bit 7.
REQ-022 In SHIFT, a pulse rising edge SHALL increment shift_count, saturating at 8.
REQ-023 ctlr_data SHALL equal shift register bit 0 (registered output); after 8 or more shifts ctlr_data SHALL be 1.
REQ-024 Latency: ctlr_data SHALL reflect button A exactly SYNC_STAGES+1 clocks after a ctlr_latch pin rise.
REQ-025 Latency: ctlr_data SHALL shift exactly SYNC_STAGES+1 clocks after a ctlr_pulse pin rise.
REQ-026 read_done SHALL assert for exactly one cycle on the shift taking shift_count from 7 to 8, and SHALL not assert again until after a reload.
REQ-027 Simultaneous synchronized latch rise and pulse rise SHALL be treated as a load; no shift occurs.
REQ-028 Debounced values SHALL update during SHIFT, but the shift register contents SHALL not change except by shifting.

Reset
REQ-029 Reset SHALL force: state IDLE; shift register 8'hFF; ctlr_data 1; shift_count 0; read_done 0; synchronizer and edge flops 0; debounced buttons 0; debounce counter 0.
REQ-030 Reset asserted mid-shift SHALL take effect immediately (asynchronously), and after release the block SHALL wait in IDLE for a fresh latch.

Structure
REQ-031 A shared package joypad_pkg SHALL hold the state enum and the button index constants BTN_A..BTN_RIGHT.
REQ-032 One sub-module, input_sync (parameterized width and stage count), SHALL implement the synchronizers; it is instantiated for the latch/pulse pair and for the buttons.

Verification
REQ-033 Scenario: hold buttons=8'h09 past debounce; pulse latch high then low; issue 8 pulses -> ctlr_data sequence 0,1,1,0,1,1,1,1, then 1 after the 8th pulse; read_done pulses once.
REQ-034 Scenario: 10 pulses after one latch -> shift_count reaches 8 and stays 8; bits 9 and 10 read 1; read_done fires exactly once.
REQ-035 Scenario: buttons=8'h01 glitching for less than DB_PERIOD, then latch -> ctlr_data=1 (bit rejected); buttons stable for 2 ticks -> ctlr_data=0 after the next latch.
REQ-036 Scenario: latch re-raised after 3 shifts with buttons=8'hFF -> shift_count returns to 0 and ctlr_data=0 within SYNC_STAGES+1 clocks.
REQ-037 Scenario: latch and pulse rise on the same clock -> state LOAD and shift_count 0; no shift occurs.
REQ-038 Scenario: reset_n asserted after 4 shifts -> ctlr_data=1, shift_count=0 and state IDLE immediately; pulses with no latch leave ctlr_data=1.
